// File: rtl/dev_host_ctrl.sv
// dev_host_ctrl -- upstream master for the dev_fsm slave port.
//
// This block takes one operation request at a time over a valid/ready
// handshake. It sends the request to dev_fsm as a command byte, then the
// optional operands, then an optional result read. Completion is reported
// on a one-cycle response strobe, which carries either the read data or a
// timeout error.
//
// Ports:
//   clk        single clock; all state updates happen on posedge
//   rst        asynchronous, active-low reset
//   req_valid  request present
//   req_ready  controller idle and able to accept a request
//   req_cmd    command byte, sent verbatim on dev_din
//   req_op1    operand 1, sent only when req_cmd[b_op_1] is set
//   req_op2    operand 2, sent only when req_cmd[b_op_2] is set
//   req_rd     follow the write phase with a result read
//   rsp_valid  one-cycle completion strobe
//   rsp_data   last read result; held until the next read completes
//   rsp_err    qualifies rsp_valid; 1 = timeout
//   dev_cs     to dev_fsm cs
//   dev_din    to dev_fsm din
//   dev_busy   from dev_fsm busy
//   dev_dout   from dev_fsm dout
//   dev_drdy   from dev_fsm drdy

package cmd_bits;
    // Bit positions inside a dev_fsm command byte.
    localparam int b_tx     = 0;
    localparam int b_op_1   = 1;
    localparam int b_op_2   = 2;
    localparam int b_addop  = 3;
    localparam int b_addres = 4;
endpackage

module dev_host_ctrl #(
    parameter int DW      = 8,
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [DW-1:0] req_cmd,
    input  logic [DW-1:0] req_op1,
    input  logic [DW-1:0] req_op2,
    input  logic          req_rd,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_err,
    output logic          dev_cs,
    output logic [DW-1:0] dev_din,
    input  logic          dev_busy,
    input  logic [DW-1:0] dev_dout,
    input  logic          dev_drdy
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_W_BUSY,
        S_CMD,
        S_OP1,
        S_OP2,
        S_R_BUSY,
        S_R_CMD,
        S_R_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    // A wait gives up on the cycle in which the counter would reach
    // TIMEOUT. That is the cycle in which the counter already holds
    // TIMEOUT-1.
    localparam logic          TO_EN   = (TIMEOUT != 0);
    localparam logic [TW-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] cmd_q, cmd_d;
    logic [DW-1:0] op1_q, op1_d;
    logic [DW-1:0] op2_q, op2_d;
    logic          rd_q, rd_d;
    logic [DW-1:0] rsp_data_q, rsp_data_d;

    logic          timeout_hit;
    logic [TW-1:0] cnt_sat;

    // The counter saturates instead of wrapping. This matters when
    // TIMEOUT=0, because in that case the wait can last forever.
    assign cnt_sat     = (cnt_q == {TW{1'b1}}) ? cnt_q : cnt_q + TW'(1);
    assign timeout_hit = TO_EN && (cnt_q >= TO_LAST);

    // State, counter, latched request and read result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            cmd_q      <= '0;
            op1_q      <= '0;
            op2_q      <= '0;
            rd_q       <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cmd_q      <= cmd_d;
            op1_q      <= op1_d;
            op2_q      <= op2_d;
            rd_q       <= rd_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    // Next-state logic. The counter defaults to zero, so it only keeps
    // counting while the FSM stays in a wait state. As a result it is
    // already clear on entry to every wait state.
    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        cmd_d      = cmd_q;
        op1_d      = op1_q;
        op2_d      = op2_q;
        rd_d       = rd_q;
        rsp_data_d = rsp_data_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    cmd_d   = req_cmd;
                    op1_d   = req_op1;
                    op2_d   = req_op2;
                    rd_d    = req_rd;
                    state_d = S_W_BUSY;
                end
            end
            S_W_BUSY: begin
                if (!dev_busy)        state_d = S_CMD;
                else if (timeout_hit) state_d = S_ERR;
                else                  cnt_d   = cnt_sat;
            end
            S_CMD: begin
                if (cmd_q[cmd_bits::b_op_1])      state_d = S_OP1;
                else if (cmd_q[cmd_bits::b_op_2]) state_d = S_OP2;
                else if (rd_q)                    state_d = S_R_BUSY;
                else                              state_d = S_DONE;
            end
            S_OP1: begin
                if (cmd_q[cmd_bits::b_op_2]) state_d = S_OP2;
                else if (rd_q)               state_d = S_R_BUSY;
                else                         state_d = S_DONE;
            end
            S_OP2: begin
                state_d = rd_q ? S_R_BUSY : S_DONE;
            end
            S_R_BUSY: begin
                if (!dev_busy)        state_d = S_R_CMD;
                else if (timeout_hit) state_d = S_ERR;
                else                  cnt_d   = cnt_sat;
            end
            S_R_CMD: begin
                state_d = S_R_WAIT;
            end
            S_R_WAIT: begin
                // If drdy and the timeout land in the same cycle, drdy wins.
                if (dev_drdy) begin
                    rsp_data_d = dev_dout;
                    state_d    = S_DONE;
                end else if (timeout_hit) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_sat;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore outputs, decoded only from the registered state and the
    // latched request fields.
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        dev_cs    = 1'b0;
        dev_din   = '0;

        case (state_q)
            S_IDLE: req_ready = 1'b1;
            S_CMD: begin
                dev_cs  = 1'b1;
                dev_din = cmd_q;
            end
            S_OP1: dev_din = op1_q;
            S_OP2: dev_din = op2_q;
            S_R_CMD: begin
                dev_cs  = 1'b1;
                dev_din = DW'(1) << cmd_bits::b_tx;
            end
            S_DONE: rsp_valid = 1'b1;
            S_ERR: begin
                rsp_valid = 1'b1;
                rsp_err   = 1'b1;
            end
            default: ;
        endcase
    end

    assign rsp_data = rsp_data_q;

endmodule
